// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants for the PS/2 keyboard front end.
//   - set-2 scancodes for the game keys (plain and E0-extended arrows)
//   - prefix bytes (E0 extended, F0 break)
//   - HID-style game keycodes
//   - decoder state enum
//   - xlate(): scancode -> game keycode (KC_NONE when unmapped)
// Optional feature macro: PS2_ARROW_KEYS_EN (maps E0 arrow keys to the
// same keycodes as WASD; when undefined, extended codes never map).
package ps2_pkg;

  localparam logic [7:0] SC_A    = 8'h1C;
  localparam logic [7:0] SC_D    = 8'h23;
  localparam logic [7:0] SC_S    = 8'h1B;
  localparam logic [7:0] SC_W    = 8'h1D;
  localparam logic [7:0] SC_ESC  = 8'h76;
  localparam logic [7:0] SC_R    = 8'h2D;

  localparam logic [7:0] SC_XLEFT  = 8'h6B;
  localparam logic [7:0] SC_XRIGHT = 8'h74;
  localparam logic [7:0] SC_XDOWN  = 8'h72;
  localparam logic [7:0] SC_XUP    = 8'h75;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] KC_NONE  = 8'h00;
  localparam logic [7:0] KC_LEFT  = 8'h04;
  localparam logic [7:0] KC_RIGHT = 8'h07;
  localparam logic [7:0] KC_DOWN  = 8'h16;
  localparam logic [7:0] KC_UP    = 8'h1A;
  localparam logic [7:0] KC_ESC   = 8'h29;
  localparam logic [7:0] KC_RST   = 8'h15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BRK,
    S_EXT,
    S_EXT_BRK
  } dec_state_t;

  function automatic logic [7:0] xlate(input logic [7:0] sc, input logic ext);
    logic [7:0] kc;
    kc = KC_NONE;
    if (!ext) begin
      case (sc)
        SC_A:    kc = KC_LEFT;
        SC_D:    kc = KC_RIGHT;
        SC_S:    kc = KC_DOWN;
        SC_W:    kc = KC_UP;
        SC_ESC:  kc = KC_ESC;
        SC_R:    kc = KC_RST;
        default: kc = KC_NONE;
      endcase
    end
`ifdef PS2_ARROW_KEYS_EN
    else begin
      case (sc)
        SC_XLEFT:  kc = KC_LEFT;
        SC_XRIGHT: kc = KC_RIGHT;
        SC_XDOWN:  kc = KC_DOWN;
        SC_XUP:    kc = KC_UP;
        default:   kc = KC_NONE;
      endcase
    end
`endif
    return kc;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 frame receiver.
//   Synchronises PS2 clock/data, detects keyboard clock falling edges,
//   shifts in an 11-bit LSB-first frame, checks start/parity/stop, and
//   discards a partial frame after TIMEOUT_CYCLES without an edge.
// Ports:
//   i_clk, i_rst_n    system clock, async active-low reset
//   i_ps2_clk/data    raw asynchronous keyboard lines
//   o_byte            received data byte (valid with o_byte_valid)
//   o_byte_valid      one-cycle pulse, good frame
//   o_frame_err       one-cycle pulse, bad framing/parity or timeout
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] r_clk_sync, r_dat_sync;
  logic                   r_clk_prev;
  logic [3:0]             r_cnt;
  logic [9:0]             r_shift;   // first ten bits of the frame, bit 0 = start
  logic [TW-1:0]          r_to;

  logic        w_clk, w_data, w_fall, w_last, w_frame_ok, w_timeout;
  logic [10:0] w_frame;

  assign w_clk   = r_clk_sync[SYNC_STAGES-1];
  assign w_data  = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk;
  assign w_last  = (r_cnt == 4'd10);
  // Check runs in the same cycle the stop bit arrives, so the byte is
  // presented one cycle after the edge.
  assign w_frame    = {w_data, r_shift};
  assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
  assign w_timeout  = ~w_fall && (r_to == TW'(TIMEOUT_CYCLES)) && (r_cnt != 4'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync   <= '1;
      r_dat_sync   <= '1;
      r_clk_prev   <= 1'b1;
      r_cnt        <= 4'd0;
      r_shift      <= '0;
      r_to         <= '0;
      o_byte       <= 8'h00;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
      r_clk_prev   <= w_clk;
      o_byte_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      if (w_fall) begin
        r_to    <= '0;
        r_shift <= {w_data, r_shift[9:1]};
        if (w_last) begin
          r_cnt <= 4'd0;
          if (w_frame_ok) begin
            o_byte       <= w_frame[8:1];
            o_byte_valid <= 1'b1;
          end else begin
            o_frame_err  <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else begin
        // Saturates while idle; clearing r_cnt makes the timeout fire once.
        if (r_to != TW'(TIMEOUT_CYCLES)) r_to <= r_to + TW'(1);
        if (w_timeout) begin
          r_cnt       <= 4'd0;
          o_frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx: PS/2 keyboard front end producing the held game keycode.
//   Decodes E0/F0 prefixes from received bytes and translates game keys.
//   Newest make wins; only a break of the currently held key clears it.
// Ports:
//   Clk, Reset_n        50 MHz clock, async active-low reset
//   PS2_CLK, PS2_DATA   raw keyboard lines
//   KEYCODE             held game keycode, 8'h00 = none
//   key_press           one-cycle pulse when KEYCODE changes to nonzero
//   frame_err           one-cycle pulse on bad frame or timeout
// Optional feature macro: PS2_ARROW_KEYS_EN (see ps2_pkg::xlate).
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] KEYCODE,
  output logic       key_press,
  output logic       frame_err
);

  logic [7:0] w_byte, w_kc;
  logic       w_byte_valid, w_make_hit, w_brk_hit;
  dec_state_t r_state;
  logic [7:0] r_keycode;
  logic       r_press;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame (
    .i_clk       (Clk),
    .i_rst_n     (Reset_n),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_data  (PS2_DATA),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (frame_err)
  );

  assign w_kc       = xlate(w_byte, (r_state == S_EXT) || (r_state == S_EXT_BRK));
  assign w_make_hit = (w_kc != KC_NONE) && (w_kc != r_keycode);  // repeat of held key is silent
  assign w_brk_hit  = (w_kc != KC_NONE) && (w_kc == r_keycode);  // only the held key releases

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_keycode <= KC_NONE;
      r_press   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (w_byte_valid) begin
        case (r_state)
          S_IDLE: begin
            if (w_byte == PFX_BRK)      r_state <= S_BRK;
            else if (w_byte == PFX_EXT) r_state <= S_EXT;
            else if (w_make_hit) begin
              r_keycode <= w_kc;
              r_press   <= 1'b1;
            end
          end
          S_EXT: begin
            if (w_byte == PFX_BRK) r_state <= S_EXT_BRK;
            else begin
              r_state <= S_IDLE;
              if (w_make_hit) begin
                r_keycode <= w_kc;
                r_press   <= 1'b1;
              end
            end
          end
          S_BRK, S_EXT_BRK: begin
            r_state <= S_IDLE;
            if (w_brk_hit) r_keycode <= KC_NONE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign KEYCODE   = r_keycode;
  assign key_press = r_press;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
module tb_ps2_keycode_rx;

  localparam int TO = 300;

  logic       Clk = 1'b0, Reset_n = 1'b0, PS2_CLK = 1'b1, PS2_DATA = 1'b1;
  logic [7:0] KEYCODE;
  logic       key_press, frame_err;

  int total = 0, bad = 0;
  int press_cnt = 0, err_cnt = 0;
  bit settled = 1'b0;

  // model: held key plus pending prefix flags
  logic [7:0] exp_kc = 8'h00;
  bit         m_brk = 1'b0, m_ext = 1'b0;
  int         exp_press, exp_err;

  // snapshots taken on the 3rd/4th/5th negedge after the last bit's falling edge
  logic [7:0] kc_k3, kc_k4;
  logic       pr_k4, pr_k5;

  always #5 Clk = ~Clk;

  ps2_keycode_rx #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
    .KEYCODE(KEYCODE), .key_press(key_press), .frame_err(frame_err)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] map(input logic [7:0] b, input bit ext);
    if (!ext) begin
      case (b)
        8'h1C: return 8'h04;
        8'h23: return 8'h07;
        8'h1B: return 8'h16;
        8'h1D: return 8'h1A;
        8'h76: return 8'h29;
        8'h2D: return 8'h15;
        default: return 8'h00;
      endcase
    end
`ifdef PS2_ARROW_KEYS_EN
    case (b)
      8'h6B: return 8'h04;
      8'h74: return 8'h07;
      8'h72: return 8'h16;
      8'h75: return 8'h1A;
      default: return 8'h00;
    endcase
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] k;
    if (b == 8'hF0) begin m_brk = 1'b1; return; end
    if (b == 8'hE0) begin m_ext = 1'b1; return; end
    k = map(b, m_ext);
    if (m_brk) begin
      if (k != 8'h00 && k == exp_kc) exp_kc = 8'h00;
    end else if (k != 8'h00 && k != exp_kc) begin
      exp_kc = k;
      exp_press = 1;
    end
    m_brk = 1'b0;
    m_ext = 1'b0;
  endtask

  // per-cycle compare while no frame is in flight
  always @(negedge Clk) begin
    press_cnt += int'(key_press);
    err_cnt   += int'(frame_err);
    if (settled && Reset_n) begin
      check("kc", int'(KEYCODE), int'(exp_kc));
      check("press_idle", int'(key_press), 0);
      check("err_idle", int'(frame_err), 0);
    end
  end

  task automatic send_bit(input logic b);
    @(negedge Clk);
    PS2_DATA = b;
    repeat (3) @(negedge Clk);
    PS2_CLK = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge Clk);
      if (k == 3) kc_k3 = KEYCODE;
      if (k == 4) begin kc_k4 = KEYCODE; pr_k4 = key_press; end
      if (k == 5) pr_k5 = key_press;
    end
    PS2_CLK = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    int p0, e0;
    logic par;
    p0 = press_cnt;
    e0 = err_cnt;
    settled = 1'b0;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(1'b1);
    repeat (4) @(negedge Clk);
    exp_press = 0;
    exp_err   = bad_par ? 1 : 0;
    if (!bad_par) model_byte(b);
    check("press_n", press_cnt - p0, exp_press);
    check("err_n", err_cnt - e0, exp_err);
    settled = 1'b1;
  endtask

  initial begin
    int p, e;
    logic [7:0] pb;
    repeat (3) @(negedge Clk);
    check("rst_kc", int'(KEYCODE), 0);
    check("rst_press", int'(key_press), 0);
    check("rst_err", int'(frame_err), 0);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    settled = 1'b1;

    // A make: latency and pulse shape
    send_frame(8'h1C, 1'b0);
    check("lat_k3", int'(kc_k3), 8'h00);
    check("lat_k4", int'(kc_k4), 8'h04);
    check("lat_press", int'(pr_k4), 1);
    check("press_width", int'(pr_k5), 0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check("a_break", int'(KEYCODE), 8'h00);

    // typematic
    p = press_cnt;
    repeat (3) send_frame(8'h1C, 1'b0);
    check("typematic_n", press_cnt - p, 1);
    check("typematic_kc", int'(KEYCODE), 8'h04);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // two keys held, newest wins
    send_frame(8'h1D, 1'b0);
    check("w_make", int'(KEYCODE), 8'h1A);
    send_frame(8'h23, 1'b0);
    check("d_make", int'(KEYCODE), 8'h07);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b0);
    check("w_brk_ignored", int'(KEYCODE), 8'h07);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h23, 1'b0);
    check("d_brk", int'(KEYCODE), 8'h00);

    // parity error, then good frame
    e = err_cnt;
    send_frame(8'h76, 1'b1);
    check("par_err_n", err_cnt - e, 1);
    check("par_err_kc", int'(KEYCODE), 8'h00);
    send_frame(8'h76, 1'b0);
    check("esc_make", int'(KEYCODE), 8'h29);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h76, 1'b0);

    // partial frame timeout
    settled = 1'b0;
    e = err_cnt;
    pb = 8'h1C;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(pb[i]);
    repeat (TO + 20) @(negedge Clk);
    check("timeout_err_n", err_cnt - e, 1);
    settled = 1'b1;
    send_frame(8'h2D, 1'b0);
    check("r_make", int'(KEYCODE), 8'h15);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h2D, 1'b0);

    // extended left arrow
    send_frame(8'hE0, 1'b0);
    send_frame(8'h6B, 1'b0);
`ifdef PS2_ARROW_KEYS_EN
    check("xleft_make", int'(KEYCODE), 8'h04);
`else
    check("xleft_make", int'(KEYCODE), 8'h00);
`endif
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h6B, 1'b0);
    check("xleft_brk", int'(KEYCODE), 8'h00);

    // reset mid-frame
    send_frame(8'h1D, 1'b0);
    settled = 1'b0;
    e = err_cnt;
    pb = 8'h23;
    send_bit(1'b0);
    for (int i = 0; i < 2; i++) send_bit(pb[i]);
    Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    check("midrst_kc", int'(KEYCODE), 0);
    check("midrst_press", int'(key_press), 0);
    check("midrst_err", int'(frame_err), 0);
    Reset_n = 1'b1;
    exp_kc = 8'h00;
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (TO + 20) @(negedge Clk);
    check("midrst_no_err", err_cnt - e, 0);
    settled = 1'b1;
    send_frame(8'h23, 1'b0);
    check("post_rst_make", int'(KEYCODE), 8'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
